// File: rtl/noc_flit_injector.sv
// Network-interface transmitter: turns a packet descriptor plus payload words into
// head/body/tail flits on a registered valid/ready link into the router local port.
module noc_flit_injector #(
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 2,
  parameter int MAX_LEN     = 4,
  parameter int SRC_X       = 0,
  parameter int SRC_Y       = 0,
  localparam int FLIT_W     = DATA_WIDTH + 2,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic [COORD_WIDTH-1:0] pkt_dest_x,
  input  logic [COORD_WIDTH-1:0] pkt_dest_y,
  input  logic [LEN_W-1:0]       pkt_len,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLIT_W-1:0]      out_data,
  output logic [15:0]            pkt_sent_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [1:0]            state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]     out_data_q, out_data_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  load_ok;
  logic [LEN_W-1:0]      len_sat;
  logic [DATA_WIDTH-1:0] head_payload;

  // The flit register may take a new flit when empty or when its current one drains.
  assign load_ok = !out_valid_q || out_ready;
  assign len_sat = (pkt_len > LEN_MAX) ? LEN_MAX : pkt_len;

  always_comb begin
    head_payload = '0;
    head_payload[COORD_WIDTH-1:0]                 = pkt_dest_x;
    head_payload[2*COORD_WIDTH-1:COORD_WIDTH]     = pkt_dest_y;
    head_payload[3*COORD_WIDTH-1:2*COORD_WIDTH]   = COORD_WIDTH'(SRC_X);
    head_payload[4*COORD_WIDTH-1:3*COORD_WIDTH]   = COORD_WIDTH'(SRC_Y);
    head_payload[4*COORD_WIDTH +: LEN_W]          = len_sat;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pkt_valid && load_ok) begin
          out_valid_d = 1'b1;
          out_data_d  = {(len_sat == '0) ? FT_SINGLE : FT_HEAD, head_payload};
          rem_d       = len_sat;
          state_d     = (len_sat == '0) ? ST_LAST : ST_BODY;
        end
      end
      ST_BODY: begin
        if (wr_valid && load_ok) begin
          out_valid_d = 1'b1;
          rem_d       = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            out_data_d = {FT_TAIL, wr_data};
            state_d    = ST_LAST;
          end else begin
            out_data_d = {FT_BODY, wr_data};
          end
        end
      end
      ST_LAST: begin
        // The final flit is already in the register; the packet completes on its handshake.
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pkt_ready    = (state_q == ST_IDLE) && load_ok;
  assign wr_ready     = (state_q == ST_BODY) && load_ok;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign pkt_sent_cnt = cnt_q;

endmodule

// File: tb/tb_noc_flit_injector.sv
// Directed bench for noc_flit_injector: packets are driven on falling edges and
// the handshakes seen before each rising edge are logged and compared to hand-computed flits.
module tb_noc_flit_injector;

  logic        clk;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [1:0]  pkt_dest_x;
  logic [1:0]  pkt_dest_y;
  logic [2:0]  pkt_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_data;
  logic [15:0] pkt_sent_cnt;

  noc_flit_injector dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_dest_x   (pkt_dest_x),
    .pkt_dest_y   (pkt_dest_y),
    .pkt_len      (pkt_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .pkt_sent_cnt (pkt_sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  logic [33:0] flits[$];
  logic [31:0] words[0:4];
  int words_taken;
  int head_cycles;
  int wr_rdy_stall;
  int hold_viol;
  int pkt_cycles;

  // Presents one descriptor, offers nw words back to back, and holds out_ready low
  // for 'stall' cycles right after the descriptor is taken. Ends once the link goes idle.
  task automatic run_pkt(input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] len,
                         input int nw, input int stall);
    int wi;
    int stall_left;
    bit desc_done;
    bit done;
    bit take_d;
    bit prev_stall;
    logic [33:0] prev_data;
    wi = 0; stall_left = 0; desc_done = 0; done = 0; prev_stall = 0; prev_data = '0;
    flits.delete();
    words_taken = 0; head_cycles = 0; wr_rdy_stall = 0; hold_viol = 0; pkt_cycles = -1;
    @(negedge clk);
    pkt_valid = 1'b1; pkt_dest_x = dx; pkt_dest_y = dy; pkt_len = len;
    out_ready = 1'b1; wr_valid = 1'b0; wr_data = '0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (prev_stall && out_data !== prev_data) hold_viol++;
      if (out_valid && out_data[33:32] == 2'b01) head_cycles++;
      if (out_valid && !out_ready && wr_ready) wr_rdy_stall++;
      if (out_valid && out_ready) flits.push_back(out_data);
      if (wr_valid && wr_ready) begin
        words_taken++;
        wi++;
      end
      take_d     = pkt_valid && pkt_ready;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (desc_done && !out_valid) begin
        done = 1;
        pkt_cycles = cyc;
      end else begin
        @(negedge clk);
        if (take_d) begin
          pkt_valid  = 1'b0;
          desc_done  = 1;
          stall_left = stall;
        end
        out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
        if (stall_left > 0) stall_left--;
        wr_valid = desc_done && (wi < nw);
        wr_data  = (wi < nw) ? words[wi] : 32'h0;
      end
    end
    if (!done) check("pkt_timeout", 64'd1, 64'd0);
    @(negedge clk);
    wr_valid = 1'b0;
    pkt_valid = 1'b0;
  endtask

  task automatic check_flits(input string tag, input logic [33:0] e0, input logic [33:0] e1,
                             input logic [33:0] e2, input logic [33:0] e3,
                             input logic [33:0] e4, input int n);
    logic [33:0] exp_f[5];
    exp_f[0] = e0; exp_f[1] = e1; exp_f[2] = e2; exp_f[3] = e3; exp_f[4] = e4;
    check({tag, "_nflits"}, 64'(flits.size()), 64'(n));
    for (int i = 0; i < n && i < flits.size(); i++) begin
      check($sformatf("%s_flit%0d", tag, i), 64'(flits[i]), 64'(exp_f[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; pkt_valid = 1'b0; pkt_dest_x = '0; pkt_dest_y = '0; pkt_len = '0;
    wr_valid = 1'b0; wr_data = '0; out_ready = 1'b1;
    words[0] = 32'hDEADBEEF; words[1] = 32'hCAFEF00D; words[2] = 32'h1234_5678;
    words[3] = 32'hA5A5_0F0F; words[4] = 32'h5555_AAAA;

    // Asynchronous reset mid-cycle
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_cnt", 64'(pkt_sent_cnt), 64'd0);
    check("rst_pkt_ready", 64'(pkt_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Normal packet, full throughput
    run_pkt(2'd2, 2'd1, 3'd2, 2, 0);
    check_flits("norm", 34'h1_0000_0206, 34'h0_DEADBEEF, 34'h2_CAFEF00D, '0, '0, 3);
    check("norm_cycles", 64'(pkt_cycles), 64'd4);
    check("norm_cnt", 64'(pkt_sent_cnt), 64'd1);

    // Back-pressure on the head
    run_pkt(2'd2, 2'd1, 3'd2, 2, 3);
    check_flits("bp", 34'h1_0000_0206, 34'h0_DEADBEEF, 34'h2_CAFEF00D, '0, '0, 3);
    check("bp_head_cycles", 64'(head_cycles), 64'd4);
    check("bp_wr_ready_stall", 64'(wr_rdy_stall), 64'd0);
    check("bp_hold_viol", 64'(hold_viol), 64'd0);
    check("bp_words", 64'(words_taken), 64'd2);
    check("bp_cnt", 64'(pkt_sent_cnt), 64'd2);

    // Single-flit packet offered a word it must not take
    run_pkt(2'd3, 2'd3, 3'd0, 1, 0);
    check_flits("single", 34'h3_0000_000F, '0, '0, '0, '0, 1);
    check("single_words", 64'(words_taken), 64'd0);
    check("single_cycles", 64'(pkt_cycles), 64'd2);
    check("single_cnt", 64'(pkt_sent_cnt), 64'd3);

    // Length saturation: 7 requested, 4 carried, fifth word left alone
    run_pkt(2'd1, 2'd2, 3'd7, 5, 0);
    check_flits("sat", 34'h1_0000_0409, 34'h0_DEADBEEF, 34'h0_CAFEF00D,
                34'h0_1234_5678, 34'h2_A5A5_0F0F, 5);
    check("sat_words", 64'(words_taken), 64'd4);
    check("sat_cnt", 64'(pkt_sent_cnt), 64'd4);

    // Reset after head and one body flit
    @(negedge clk);
    pkt_valid = 1'b1; pkt_dest_x = 2'd2; pkt_dest_y = 2'd1; pkt_len = 3'd2; out_ready = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0;
    check("mid_head", 64'(out_data), 64'h1_0000_0206);
    wr_valid = 1'b1; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    wr_valid = 1'b0;
    check("mid_body", 64'(out_data), 64'h0_DEADBEEF);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_cnt", 64'(pkt_sent_cnt), 64'd0);
    check("mid_rst_pkt_ready", 64'(pkt_ready), 64'd1);
    check("mid_rst_wr_ready", 64'(wr_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    words[0] = 32'h0BAD_CAFE;
    run_pkt(2'd3, 2'd0, 3'd1, 1, 0);
    check_flits("post", 34'h1_0000_0103, 34'h2_0BAD_CAFE, '0, '0, '0, 2);
    check("post_cnt", 64'(pkt_sent_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
